// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types and constants for the pipeline hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

   localparam int REG_AW = 5;
   localparam int FWD_RF = 0;
   // Storage width of the latency countdown; the scoreboard's LATW must not exceed it.
   localparam int CNT_W  = 8;

   typedef struct packed {
      logic              valid;
      logic              wen;
      logic [REG_AW-1:0] rd;
      logic [CNT_W-1:0]  cnt;
   } sb_entry_t;

   function automatic sb_entry_t sb_advance(input sb_entry_t e);
      sb_entry_t r;
      r = e;
      if (e.cnt != '0) r.cnt = e.cnt - CNT_W'(1);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_check.sv
`default_nettype none
// ============================================================================
// Module      : hazard_src_check
// Description : Per-source-channel match, youngest-first priority and
//               forward/stall decision against the scoreboard entries.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_src_check
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int SELW  = 2
) (
   input  sb_entry_t          entries [DEPTH],
   input  logic [REG_AW-1:0]  src,
   output logic [SELW-1:0]    fwd_sel,
   output logic               stall_req
);

   logic            w_hit;
   logic            w_ready;
   logic [SELW-1:0] w_idx;

   // Scan oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      w_hit   = 1'b0;
      w_ready = 1'b0;
      w_idx   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (entries[k].valid && entries[k].wen &&
             entries[k].rd == src && src != '0) begin
            w_hit   = 1'b1;
            w_ready = (entries[k].cnt == '0);
            w_idx   = SELW'(k + 1);
         end
      end
   end

   assign fwd_sel   = (w_hit && w_ready) ? w_idx : SELW'(FWD_RF);
   assign stall_req = w_hit && !w_ready;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : In-order pipeline scoreboard producing operand forwarding
//               selects and a load-use stall. Optional stall counter enabled
//               by defining HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int DEPTH = 3,
   parameter  int NSRC  = 2,
   parameter  int LATW  = 2,
   localparam int SELW  = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid,
   input  logic                   issue_wen,
   input  logic [REG_AW-1:0]      issue_rd,
   input  logic [LATW-1:0]        issue_lat,
   input  logic [NSRC*REG_AW-1:0] src_rs,
   input  logic                   stall_ext,
   input  logic                   flush,
   output logic [NSRC*SELW-1:0]   fwd_sel,
   output logic                   stall,
   output logic                   issue_ready
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]            stall_cycles
`endif
);

   // r_entries[0] is pipeline entry 1 (EX), r_entries[DEPTH-1] is entry DEPTH (WB).
   sb_entry_t       r_entries [DEPTH];
   logic [NSRC-1:0] w_stall_req;
   logic            w_issue;

   generate
      for (genvar g = 0; g < NSRC; g++) begin : g_src
         hazard_src_check #(
            .DEPTH (DEPTH),
            .SELW  (SELW)
         ) u_check (
            .entries   (r_entries),
            .src       (src_rs[g*REG_AW +: REG_AW]),
            .fwd_sel   (fwd_sel[g*SELW +: SELW]),
            .stall_req (w_stall_req[g])
         );
      end
   endgenerate

   assign stall       = issue_valid && (|w_stall_req);
   assign issue_ready = !stall && !stall_ext;
   assign w_issue     = issue_valid && !stall && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_entries[k] <= '0;
      end else if (!stall_ext) begin
         if (w_issue) begin
            r_entries[0].valid <= 1'b1;
            r_entries[0].wen   <= issue_wen;
            r_entries[0].rd    <= issue_rd;
            r_entries[0].cnt   <= CNT_W'(issue_lat);
         end else begin
            r_entries[0] <= '0;
         end
         for (int k = 1; k < DEPTH; k++) r_entries[k] <= sb_advance(r_entries[k-1]);
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_stall_cycles <= '0;
      else if (stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard
//               (DEPTH=3, NSRC=2, LATW=2, so each fwd_sel channel is 2 bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic       issue_wen;
   logic [4:0] issue_rd;
   logic [1:0] issue_lat;
   logic [9:0] src_rs;
   logic       stall_ext;
   logic       flush;
   logic [3:0] fwd_sel;
   logic       stall;
   logic       issue_ready;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   hazard_scoreboard #(
      .DEPTH (3),
      .NSRC  (2),
      .LATW  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_wen   (issue_wen),
      .issue_rd    (issue_rd),
      .issue_lat   (issue_lat),
      .src_rs      (src_rs),
      .stall_ext   (stall_ext),
      .flush       (flush),
      .fwd_sel     (fwd_sel),
      .stall       (stall),
      .issue_ready (issue_ready)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                        input logic [1:0] lat, input logic [4:0] rs1, input logic [4:0] rs2);
      issue_valid = v;
      issue_wen   = w;
      issue_rd    = rd;
      issue_lat   = lat;
      src_rs      = {rs2, rs1};
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall_ext = 1'b0; flush = 1'b0;
      drive(1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 5'd0);
      check("rst_fwd", 32'(fwd_sel), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_ready", 32'(issue_ready), 32'h1);
      #9 rst = 1'b0;
      tick();

      // ALU back-to-back
      drive(1'b1, 1'b1, 5'd5, 2'd0, 5'd0, 5'd0);
      tick();
      drive(1'b1, 1'b1, 5'd6, 2'd0, 5'd5, 5'd0);
      check("alu_fwd", 32'(fwd_sel), 32'h1);
      check("alu_stall", 32'(stall), 32'h0);
      tick();

      // entries: x6, x5 ; load x7 while reading both older producers
      drive(1'b1, 1'b1, 5'd7, 2'd1, 5'd6, 5'd5);
      check("two_src_fwd", 32'(fwd_sel), 32'h9);
      tick();
      drive(1'b1, 1'b1, 5'd8, 2'd0, 5'd0, 5'd7);
      check("ld_use_stall", 32'(stall), 32'h1);
      check("ld_use_fwd", 32'(fwd_sel), 32'h0);
      check("ld_use_ready", 32'(issue_ready), 32'h0);
      tick();
      check("ld_use_stall2", 32'(stall), 32'h0);
      check("ld_use_fwd2", 32'(fwd_sel), 32'h8);
      check("ld_use_ready2", 32'(issue_ready), 32'h1);
      tick();

      // Priority: x3 in entries 1 and 3, x4 in entry 2
      drive(1'b1, 1'b1, 5'd3, 2'd0, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b1, 5'd4, 2'd0, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b1, 5'd3, 2'd0, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd3, 5'd3);
      check("prio_fwd", 32'(fwd_sel), 32'h5);
      check("prio_stall", 32'(stall), 32'h0);
      drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd4, 5'd3);
      check("prio_mix_fwd", 32'(fwd_sel), 32'h6);

      // x0 producer with load latency must be invisible
      drive(1'b1, 1'b1, 5'd0, 2'd1, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0);
      check("x0_fwd", 32'(fwd_sel), 32'h0);
      check("x0_stall", 32'(stall), 32'h0);

      // Flush drops the decode instruction
      flush = 1'b1;
      drive(1'b1, 1'b1, 5'd9, 2'd0, 5'd0, 5'd0); tick();
      flush = 1'b0;
      drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd9, 5'd0);
      check("flush_fwd", 32'(fwd_sel), 32'h0);
      tick();

      // Stall together with flush: bubble, nothing recorded
      drive(1'b1, 1'b1, 5'd10, 2'd1, 5'd0, 5'd0); tick();
      flush = 1'b1;
      drive(1'b1, 1'b1, 5'd11, 2'd0, 5'd10, 5'd0);
      check("sf_stall", 32'(stall), 32'h1);
      tick();
      flush = 1'b0;
      drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd11, 5'd10);
      check("sf_fwd", 32'(fwd_sel), 32'h8);
      check("sf_stall2", 32'(stall), 32'h0);
      tick();

      // External freeze during load-use
      drive(1'b1, 1'b1, 5'd12, 2'd1, 5'd0, 5'd0); tick();
      stall_ext = 1'b1;
      drive(1'b1, 1'b1, 5'd13, 2'd0, 5'd12, 5'd0);
      for (int i = 0; i < 3; i++) begin
         check("ext_stall", 32'(stall), 32'h1);
         check("ext_fwd", 32'(fwd_sel), 32'h0);
         check("ext_ready", 32'(issue_ready), 32'h0);
         tick();
      end
      stall_ext = 1'b0;
      #1;
      check("ext_rel_stall", 32'(stall), 32'h1);
      tick();
      check("ext_rel_stall2", 32'(stall), 32'h0);
      check("ext_rel_fwd", 32'(fwd_sel), 32'h2);
      check("ext_rel_ready", 32'(issue_ready), 32'h1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd13, 5'd0);
      check("ext_issued_fwd", 32'(fwd_sel), 32'h1);
      tick();

      // Asynchronous reset in the middle of a load-use stall
      drive(1'b1, 1'b1, 5'd14, 2'd1, 5'd0, 5'd0); tick();
      drive(1'b1, 1'b1, 5'd15, 2'd0, 5'd14, 5'd0);
      check("pre_rst_stall", 32'(stall), 32'h1);
`ifdef HAZARD_STATS_EN
      check("stall_cycles", stall_cycles, 32'd6);
`endif
      #1 rst = 1'b1;
      #1;
      check("async_rst_stall", 32'(stall), 32'h0);
      check("async_rst_fwd", 32'(fwd_sel), 32'h0);
      check("async_rst_ready", 32'(issue_ready), 32'h1);
`ifdef HAZARD_STATS_EN
      check("stall_cycles_rst", stall_cycles, 32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_stall", 32'(stall), 32'h0);
      check("post_rst_fwd", 32'(fwd_sel), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The parameter DEPTH, default 3, SHALL set the number of tracked in-flight stages after decode; entry 1 is the youngest (EX) and entry DEPTH the oldest (WB).
REQ-002 The parameter NSRC, default 2, SHALL set the number of source-operand channels checked per cycle.
REQ-003 The parameter LATW, default 2, SHALL set the width of the issue latency field.
REQ-004 The derived width SELW SHALL equal clog2(DEPTH+1).
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 issue_valid  input  1  the instruction in decode requests issue.
REQ-008 issue_wen  input  1  the issuing instruction writes a register.
REQ-009 issue_rd  input  5  destination register of the issuing instruction.
REQ-010 issue_lat  input  LATW  stage advances after issue before its result can be forwarded (0 = ALU, 1 = load).
REQ-011 src_rs  input  NSRC*5  source registers of the decode instruction; channel n is bits [5n+4:5n].
REQ-012 stall_ext  input  1  external freeze (memory wait); holds the whole pipeline.
REQ-013 flush  input  1  kills the decode instruction (branch taken).
REQ-014 fwd_sel  output  NSRC*SELW  per channel: 0 = register file, k = forward from entry k.
REQ-015 stall  output  1  decode instruction blocked by a not-yet-ready producer.
REQ-016 issue_ready  output  1  equals !stall && !stall_ext.

Function
REQ-017 Each entry SHALL hold {valid, wen, rd, cnt[LATW]}.
REQ-018 A channel SHALL match entry k when valid && wen && rd == src && src != 0.
REQ-019 A channel SHALL select the lowest-index (youngest) matching entry; if that entry has cnt == 0, fwd_sel = k, otherwise fwd_sel = 0 and the channel requests a stall.
REQ-020 stall SHALL be the OR of all channel stall requests gated by issue_valid; fwd_sel and stall SHALL be combinational from current state and inputs.
REQ-021 Advance (stall_ext = 0): entry[k] <= entry[k-1] for k >= 2, with cnt decremented and saturating at 0; the entry leaving DEPTH is dropped.
REQ-022 Advance: entry[1] SHALL load {1, issue_wen, issue_rd, issue_lat} when issue_valid && !stall && !flush, and a bubble (valid = 0) otherwise.
REQ-023 stall_ext = 1 SHALL hold every entry, cnt included, unchanged, regardless of flush and issue_valid.
REQ-024 When stall and flush are both asserted (stall_ext = 0), a bubble SHALL be inserted and the instruction SHALL NOT be recorded.
REQ-025 A producer with issue_lat = L SHALL become forwardable exactly L advances after it enters entry 1; a load (L = 1) followed by a dependent instruction SHALL cost exactly 1 stall cycle.
REQ-026 Register x0 SHALL never cause forwarding or stall.

Reset
REQ-027 rst SHALL clear every entry's valid, wen, rd and cnt to 0 immediately, independent of clk; as a result fwd_sel = 0, stall = 0 and issue_ready = 1 while rst is high.
REQ-028 A reset asserted mid-stall SHALL discard all in-flight entries with no residual stall after release.

Configuration
REQ-029 With macro HAZARD_STATS_EN defined, the block SHALL add the output stall_cycles (32 bits): it increments on each cycle with stall = 1, saturates at 0xFFFFFFFF and clears on rst.
REQ-030 Without HAZARD_STATS_EN, the port and the counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 The shared package SHALL hold the scoreboard entry struct typedef, the register-address width constant (5) and the constant FWD_RF = 0.
REQ-032 The per-channel match/priority logic SHALL be one sub-module, hazard_src_check, instantiated NSRC times.

Verification
REQ-033 ALU back-to-back: issue x5 (lat 0), then rs1 = x5 on the next cycle -> fwd_sel ch0 = 1 and stall = 0.
REQ-034 Load-use: issue load x7 (lat 1), then rs2 = x7 -> stall = 1 for 1 cycle, then fwd_sel ch1 = 2 and stall = 0.
REQ-035 Priority: x3 written at entries 1 and 3, both lat 0, with rs1 = rs2 = x3 -> both channels select 1.
REQ-036 x0 and flush: rd = x0 with rs1 = x0 -> fwd_sel = 0 and stall = 0; flush with issue_valid -> entry 1 valid = 0 on the next cycle.
REQ-037 stall_ext held 3 cycles during a load-use -> entries and cnt frozen and stall persists; after release the dependent instruction issues after exactly 1 further stall cycle.
REQ-038 Async reset mid-stall clears state and outputs without a clock edge; with HAZARD_STATS_EN, stall_cycles equals the count of stall cycles before reset, then 0 after reset.
